// File: rtl/round_controller.sv
// Game-round sequencer between the seconds timer and the display stage.
// Drives the timer, judges color submissions against the target and accumulates a saturating score.
module round_controller #(
   parameter int unsigned ROUND_SECS  = 9,
   parameter int unsigned MAX_ROUNDS  = 5,
   parameter int unsigned TOL         = 1,
   parameter int unsigned HOLD_CYCLES = 100
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       start,
   input  logic       submit,
   input  logic [8:0] player_color,
   input  logic [8:0] target_color,
   input  logic [3:0] sec_ones,
   input  logic [3:0] sec_tens,
   output logic       timer_resetn,
   output logic       timer_enable,
   output logic       new_target,
   output logic [3:0] round_num,
   output logic [7:0] score,
   output logic       result_valid,
   output logic       match,
   output logic       timeout,
   output logic       game_over
);

   localparam int unsigned SEC_W   = 7;
   localparam int unsigned SCORE_W = 8;
   localparam int unsigned HOLD_W  = $clog2(HOLD_CYCLES + 1);

   localparam logic [SEC_W-1:0]  SECS_LIM   = SEC_W'(ROUND_SECS);
   localparam logic [3:0]        LAST_ROUND = 4'(MAX_ROUNDS);
   localparam logic [3:0]        TOL_L      = 4'(TOL);
   localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_PLAY,
      S_JUDGE,
      S_SHOW,
      S_DONE
   } state_t;

   state_t             state, state_d;
   logic [3:0]         round_d;
   logic [SCORE_W-1:0] score_d;
   logic [SEC_W-1:0]   elapsed_q, elapsed_d;
   logic [HOLD_W-1:0]  hold_cnt, hold_cnt_d;
   logic               match_d, timeout_d;
   logic [SEC_W-1:0]   elapsed_c;
   logic [SCORE_W:0]   sum_c;
   logic               color_ok_c;

   function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
      return (d > 4'd9) ? 4'd9 : d;
   endfunction

   function automatic logic chan_ok(input logic [2:0] a, input logic [2:0] b);
      logic [3:0] diff;
      diff = (a >= b) ? (4'(a) - 4'(b)) : (4'(b) - 4'(a));
      return diff <= TOL_L;
   endfunction

   // Elapsed seconds from the timer digits, non-BCD digits read as 9
   always_comb begin
      elapsed_c = SEC_W'(bcd_clamp(sec_tens)) * SEC_W'(10) + SEC_W'(bcd_clamp(sec_ones));
      sum_c     = (SCORE_W+1)'(score) + (SCORE_W+1)'(1) + (SCORE_W+1)'(SECS_LIM - elapsed_q);
      color_ok_c = chan_ok(player_color[8:6], target_color[8:6]) &&
                   chan_ok(player_color[5:3], target_color[5:3]) &&
                   chan_ok(player_color[2:0], target_color[2:0]);
   end

   // Next-state and next-datapath decode
   always_comb begin
      state_d    = state;
      round_d    = round_num;
      score_d    = score;
      elapsed_d  = elapsed_q;
      hold_cnt_d = hold_cnt;
      match_d    = match;
      timeout_d  = timeout;
      unique case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_LOAD;
               round_d = 4'd1;
               score_d = '0;
            end
         end
         S_LOAD: state_d = S_PLAY;
         S_PLAY: begin
            if (submit) begin
               // Late submit on the limit cycle is clamped so the bonus never underflows
               elapsed_d = (elapsed_c > SECS_LIM) ? SECS_LIM : elapsed_c;
               state_d   = S_JUDGE;
            end else if (elapsed_c >= SECS_LIM) begin
               timeout_d = 1'b1;
               elapsed_d = SECS_LIM;
               state_d   = S_JUDGE;
            end
         end
         S_JUDGE: begin
            match_d = !timeout && color_ok_c;
            if (!timeout && color_ok_c) begin
               score_d = (sum_c > (SCORE_W+1)'(255)) ? SCORE_W'(255) : sum_c[SCORE_W-1:0];
            end
            hold_cnt_d = '0;
            state_d    = S_SHOW;
         end
         S_SHOW: begin
            if (hold_cnt == HOLD_LAST) begin
               if (round_num == LAST_ROUND) begin
                  state_d = S_DONE;
               end else begin
                  round_d = round_num + 4'd1;
                  state_d = S_LOAD;
               end
            end else begin
               hold_cnt_d = hold_cnt + HOLD_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (state_d == S_LOAD) begin
         match_d   = 1'b0;
         timeout_d = 1'b0;
      end
   end

   // State, datapath and registered Moore outputs
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state        <= S_IDLE;
         round_num    <= '0;
         score        <= '0;
         elapsed_q    <= '0;
         hold_cnt     <= '0;
         match        <= 1'b0;
         timeout      <= 1'b0;
         timer_resetn <= 1'b0;
         timer_enable <= 1'b0;
         new_target   <= 1'b0;
         result_valid <= 1'b0;
         game_over    <= 1'b0;
      end else begin
         state        <= state_d;
         round_num    <= round_d;
         score        <= score_d;
         elapsed_q    <= elapsed_d;
         hold_cnt     <= hold_cnt_d;
         match        <= match_d;
         timeout      <= timeout_d;
         timer_resetn <= (state_d == S_PLAY) || (state_d == S_JUDGE) || (state_d == S_SHOW);
         timer_enable <= (state_d == S_PLAY);
         new_target   <= (state_d == S_LOAD);
         result_valid <= (state == S_JUDGE);
         game_over    <= (state_d == S_DONE);
      end
   end

endmodule

// File: tb/tb_round_controller.sv
// Bench for round_controller: table-driven rounds with a result scoreboard,
// plus hand-written reset, DONE-gating and saturation sequences.
module tb_round_controller;

   logic       clk;
   logic       resetn;
   logic       start, start_b;
   logic       submit;
   logic [8:0] player_color, target_color;
   logic [3:0] sec_ones, sec_tens;

   logic       timer_resetn, timer_enable, new_target, result_valid, match, timeout, game_over;
   logic [3:0] round_num;
   logic [7:0] score;

   logic       timer_resetn_b, timer_enable_b, new_target_b, result_valid_b, match_b, timeout_b, game_over_b;
   logic [3:0] round_num_b;
   logic [7:0] score_b;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [8:0] target;
      logic [8:0] player;
      logic [3:0] tens;
      logic [3:0] ones;
      bit         do_submit;
      bit         exp_match;
      bit         exp_timeout;
      logic [7:0] exp_score;
   } vec_t;

   typedef struct {
      bit         m;
      bit         t;
      logic [7:0] s;
   } exp_t;

   vec_t vecs[10];
   exp_t sb[$];
   exp_t mon_e;
   logic [7:0] sat_exp[3];

   round_controller #(.ROUND_SECS(9), .MAX_ROUNDS(5), .TOL(1), .HOLD_CYCLES(3)) dut (
      .clk(clk), .resetn(resetn), .start(start), .submit(submit),
      .player_color(player_color), .target_color(target_color),
      .sec_ones(sec_ones), .sec_tens(sec_tens),
      .timer_resetn(timer_resetn), .timer_enable(timer_enable), .new_target(new_target),
      .round_num(round_num), .score(score), .result_valid(result_valid),
      .match(match), .timeout(timeout), .game_over(game_over)
   );

   round_controller #(.ROUND_SECS(99), .MAX_ROUNDS(3), .TOL(1), .HOLD_CYCLES(3)) dut_b (
      .clk(clk), .resetn(resetn), .start(start_b), .submit(submit),
      .player_color(player_color), .target_color(target_color),
      .sec_ones(sec_ones), .sec_tens(sec_tens),
      .timer_resetn(timer_resetn_b), .timer_enable(timer_enable_b), .new_target(new_target_b),
      .round_num(round_num_b), .score(score_b), .result_valid(result_valid_b),
      .match(match_b), .timeout(timeout_b), .game_over(game_over_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Scoreboard pop on every judged round of the main instance
   always @(negedge clk) begin
      if (result_valid === 1'b1) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rv_unexpected: got result_valid=1 expected no pending result");
         end else begin
            mon_e = sb.pop_front();
            check("sb_match", match, mon_e.m);
            check("sb_timeout", timeout, mon_e.t);
            check("sb_score", score, mon_e.s);
         end
      end
   end

   task automatic play_round(input vec_t v);
      exp_t e;
      for (int k = 0; k < 50 && new_target !== 1'b1; k++) step();
      check("new_target_wait", new_target, 1);
      target_color = v.target;
      player_color = v.player;
      sec_tens = 4'd0;
      sec_ones = 4'd0;
      step();
      check("play_timer", {timer_resetn, timer_enable}, 2'b11);
      sec_tens = v.tens;
      sec_ones = v.ones;
      submit   = v.do_submit;
      e.m = v.exp_match;
      e.t = v.exp_timeout;
      e.s = v.exp_score;
      sb.push_back(e);
      step();
      submit = 1'b0;
      check("enable_drop", timer_enable, 0);
      step();
      check("rv_latency", result_valid, 1);
      step();
      check("rv_pulse", result_valid, 0);
      sec_tens = 4'd0;
      sec_ones = 4'd0;
   endtask

   task automatic wait_game_over();
      for (int k = 0; k < 50 && game_over !== 1'b1; k++) step();
      check("game_over_wait", game_over, 1);
   endtask

   initial begin
      //             target   player   tens  ones  sub  match tmo  score
      vecs[0] = '{9'o357, 9'o357, 4'd0, 4'd3, 1'b1, 1'b1, 1'b0, 8'd7};
      vecs[1] = '{9'o357, 9'o266, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 8'd17};
      vecs[2] = '{9'o357, 9'o155, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 8'd17};
      vecs[3] = '{9'o357, 9'o357, 4'd0, 4'd9, 1'b0, 1'b0, 1'b1, 8'd17};
      vecs[4] = '{9'o357, 9'o357, 4'd0, 4'd9, 1'b1, 1'b1, 1'b0, 8'd18};
      vecs[5] = '{9'o357, 9'o357, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 8'd10};
      vecs[6] = '{9'o000, 9'o001, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 8'd20};
      vecs[7] = '{9'o777, 9'o666, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 8'd30};
      vecs[8] = '{9'o444, 9'o535, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 8'd40};
      vecs[9] = '{9'o123, 9'o032, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 8'd50};
      sat_exp[0] = 8'd100;
      sat_exp[1] = 8'd200;
      sat_exp[2] = 8'd255;

      resetn = 1'b0; start = 1'b0; start_b = 1'b0; submit = 1'b0;
      player_color = '0; target_color = '0; sec_ones = '0; sec_tens = '0;
      step();
      step();
      check("rst_timer_resetn", timer_resetn, 0);
      check("rst_timer_enable", timer_enable, 0);
      check("rst_new_target", new_target, 0);
      check("rst_round_num", round_num, 0);
      check("rst_score", score, 0);
      check("rst_result_valid", result_valid, 0);
      check("rst_match", match, 0);
      check("rst_timeout", timeout, 0);
      check("rst_game_over", game_over, 0);
      resetn = 1'b1;
      step();

      // Start, enter PLAY, then abort with a mid-game reset
      start = 1'b1;
      step();
      start = 1'b0;
      check("load_new_target", new_target, 1);
      check("load_round_num", round_num, 1);
      check("load_timer_resetn", timer_resetn, 0);
      step();
      check("play_new_target", new_target, 0);
      check("play_timer_resetn", timer_resetn, 1);
      check("play_timer_enable", timer_enable, 1);
      resetn = 1'b0;
      step();
      check("abort_timer_resetn", timer_resetn, 0);
      check("abort_timer_enable", timer_enable, 0);
      check("abort_round_num", round_num, 0);
      check("abort_score", score, 0);
      check("abort_game_over", game_over, 0);
      resetn = 1'b1;
      step();

      // Game 1: match, tolerance, mismatch, timeout, submit-on-limit
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 5; i++) play_round(vecs[i]);
      wait_game_over();
      check("done_round_num", round_num, 5);
      check("done_score", score, 18);
      check("done_timer_resetn", timer_resetn, 0);
      check("done_match_held", match, 1);

      submit = 1'b1;
      step();
      submit = 1'b0;
      step();
      check("done_submit_ignored_go", game_over, 1);
      check("done_submit_ignored_score", score, 18);

      // Restart from DONE, game 2: all rounds matched at elapsed 0
      start = 1'b1;
      step();
      start = 1'b0;
      check("restart_new_target", new_target, 1);
      check("restart_round_num", round_num, 1);
      check("restart_score", score, 0);
      check("restart_game_over", game_over, 0);
      for (int i = 5; i < 10; i++) play_round(vecs[i]);
      wait_game_over();
      check("game2_score", score, 50);
      check("game2_round_num", round_num, 5);

      // Saturation on the 99-second, 3-round instance
      start_b = 1'b1;
      step();
      start_b = 1'b0;
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 50 && new_target_b !== 1'b1; k++) step();
         check("sat_new_target_wait", new_target_b, 1);
         target_color = 9'o357;
         player_color = 9'o357;
         sec_tens = 4'd0;
         sec_ones = 4'd0;
         step();
         submit = 1'b1;
         step();
         submit = 1'b0;
         step();
         check("sat_rv", result_valid_b, 1);
         check("sat_match", match_b, 1);
         check("sat_score", score_b, sat_exp[r]);
      end
      for (int k = 0; k < 50 && game_over_b !== 1'b1; k++) step();
      check("sat_game_over", game_over_b, 1);
      check("sat_round_num", round_num_b, 3);
      check("sat_final_score", score_b, 255);
      check("a_still_done", game_over, 1);

      step();
      check("sb_drain", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/round_controller.md
Name: round_controller

Overview:
- Game-round sequencer that sits directly downstream of the seconds timer.
- Consumes the timer's BCD ones/tens digits, drives the timer's resetn/enable, and accepts the player's color submission.
- Judges each submission against the target color and accumulates a time-bonus score over a fixed number of rounds.
- Results and score feed the display/HEX stage.

Parameters:
- ROUND_SECS, 9: round time limit in seconds (legal 1..99).
- MAX_ROUNDS, 5: rounds per game (legal 1..15).
- TOL, 1: per-channel match tolerance, in LSBs of a 3-bit channel.
- HOLD_CYCLES, 100: cycles spent in SHOW (legal >= 1).

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset.
- start  in  1  single-cycle pulse; begins a game.
- submit  in  1  single-cycle pulse; player locks in a color.
- player_color  in  9  {R[8:6],G[5:3],B[2:0]}.
- target_color  in  9  same packing; stable from new_target until the next new_target.
- sec_ones  in  4  timer ones digit, BCD.
- sec_tens  in  4  timer tens digit, BCD.
- timer_resetn  out  1  active-low reset to the timer.
- timer_enable  out  1  timer count enable.
- new_target  out  1  one-cycle pulse requesting a fresh target color.
- round_num  out  4  current round, 1-based; 0 when idle.
- score  out  8  accumulated score, saturating.
- result_valid  out  1  one-cycle pulse when a round is judged.
- match  out  1  last round matched; held until next LOAD.
- timeout  out  1  last round expired; held until next LOAD.
- game_over  out  1  high in DONE.

Behaviour:
- Reset: clk is the clock; resetn is synchronous, active-low.
  - On reset: state=IDLE, timer_resetn=0, timer_enable=0, new_target=0, round_num=0, score=0.
  - Also on reset: result_valid=0, match=0, timeout=0, game_over=0.
  - Reset mid-game aborts immediately to these values.
- All outputs are registered. Moore decode from the state register.
- States: IDLE, LOAD, PLAY, JUDGE, SHOW, DONE.
- IDLE: timer_resetn=0. On start, go to LOAD with round_num<=1 and score<=0.
- LOAD (1 cycle):
  - new_target=1, timer_resetn=0; clear match and timeout.
  - Next state is PLAY.
- PLAY:
  - timer_resetn=1, timer_enable=1.
  - elapsed = 10*min(sec_tens,9) + min(sec_ones,9), 7-bit unsigned.
  - submit: capture elapsed into elapsed_q, go to JUDGE with timer_enable dropping the same edge.
  - Otherwise, if elapsed >= ROUND_SECS: set timeout=1, elapsed_q=ROUND_SECS, go to JUDGE.
  - Submit and timeout in the same cycle: submit wins.
- JUDGE (1 cycle):
  - timer_enable=0, timer_resetn=1; the timer is frozen so digits remain visible.
  - A round is a match when not timeout and, for each channel, |player-target| <= TOL, compared as 4-bit unsigned difference.
  - On match: score <= min(255, score + 1 + (ROUND_SECS - elapsed_q)).
  - On no match: score is unchanged.
  - result_valid=1 for exactly this cycle's output; match is registered.
  - Next state is SHOW.
- SHOW:
  - Counts HOLD_CYCLES cycles; submit and start are ignored.
  - Then, if round_num == MAX_ROUNDS, go to DONE.
  - Otherwise round_num <= round_num+1 and go to LOAD.
- DONE:
  - game_over=1, timer_resetn=0; score and round_num hold.
  - start clears score, sets round_num=1, deasserts game_over, goes to LOAD.
- Input gating: start is ignored outside IDLE and DONE; submit is ignored outside PLAY.
- Latency:
  - submit at edge N: result_valid high during the cycle after edge N+1.
  - timer_enable low from edge N.
  - new_target pulse one cycle after start is sampled.
- Width rules:
  - ROUND_SECS - elapsed_q never underflows, because elapsed_q <= ROUND_SECS.
  - Score addition is done in 9 bits, then saturated.

Test Plan:
1. Reset, then start. Expect one new_target pulse, round_num=1, timer_resetn high and timer_enable high in PLAY. Assert resetn=0 mid-PLAY: next edge all outputs return to reset values.
2. target=9'o357, player=9'o357, submit at elapsed 3 (tens=0, ones=3), ROUND_SECS=9. Expect match=1, timeout=0, score 0->7, one result_valid pulse.
3. target=9'o357, player=9'o266 (each channel off by 1), TOL=1, submit at elapsed 0. Expect match=1, score +10. With player=9'o155 (R off by 2): expect match=0, score unchanged.
4. No submit, digits advance to tens=0, ones=9. Expect timeout=1, match=0, score unchanged. Then drive submit and timeout in the same cycle: expect match judged normally with timeout=0.
5. Full game, MAX_ROUNDS=5, all rounds matched at elapsed 0. Expect score=50, game_over=1 after the 5th SHOW. Submit in DONE is ignored; start restarts at round 1 with score 0.
6. Saturation: preload via 30 matched rounds (MAX_ROUNDS=15 run twice without start-clear is not possible, so set ROUND_SECS=99, MAX_ROUNDS=3). Three submits at elapsed 0 add 100 each; expect score 100, 200, then 255 saturated.
